fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the datapath. Owns the PC, issues requests to instruction
//  memory over a req/ready handshake, and presents one instruction at a time (instr, instr_pc, opcode).
//  Absorbs datapath stalls with a one-entry skid buffer and flushes on branch/jump redirect.
// PARAMETERS
//  ADDR_W    32          PC / imem address width
//  RESET_PC  32'h0000_0000  first fetch address after reset (low 2 bits must be 0)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst             in   1       synchronous, active-high reset
//  imem_req        out  1       fetch request to instruction memory
//  imem_addr       out  ADDR_W  word-aligned fetch address
//  imem_ready      in   1       request accepted; imem_rdata valid this same cycle
//  imem_rdata      in   32      fetched instruction word
//  stall           in   1       datapath cannot accept an instruction this cycle
//  redirect_valid  in   1       branch/jump taken; flush and refetch
//  redirect_pc     in   ADDR_W  redirect target (bits [1:0] ignored, forced 0)
//  instr_valid     out  1       instr/instr_pc/pc_plus4/opcode valid
//  instr           out  32      current instruction
//  instr_pc        out  ADDR_W  address of instr
//  pc_plus4        out  ADDR_W  instr_pc + 4 (mod 2^ADDR_W)
//  opcode          out  6       instr[31:26]
// BEHAVIOUR
//  - Reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc_plus4=0, skid empty,
//    kill=0, state=IDLE. rst mid-transaction abandons any outstanding request; its response is ignored.
//  - imem protocol: while imem_req=1, imem_addr is held stable until the cycle imem_ready=1 (transfer).
//    imem_ready with imem_req=0 is ignored.
//  - Consume: instr_valid & !stall. Output regs change only on consume, capture into empty slot, or flush.
//  - States: IDLE -> FETCH one cycle after rst deasserts (imem_req=1, addr=RESET_PC).
//    FETCH: on transfer, capture word; next addr = addr+4; stay FETCH if a slot will be free next cycle,
//    else go FULL (imem_req=0). FULL: output and skid both occupied; return to FETCH on consume.
//  - Capture path: transfer with output empty or being consumed and skid empty -> output regs next cycle
//    (latency: imem_ready cycle -> instr_valid next cycle). Otherwise -> skid; skid moves to output on consume.
//  - Throughput: 1 instr/cycle when imem_ready=1 and stall=0 continuously.
//  - Redirect (priority over stall and capture): next cycle instr_valid=0, skid cleared.
//    If no request outstanding, or imem_ready=1 that cycle: response (if any) discarded,
//    imem_req=1 at redirect_pc next cycle.
//    If request outstanding and imem_ready=0: set kill; keep req/addr stable; on transfer discard data,
//    clear kill, request redirect_pc next cycle. Repeated redirects while kill=1: latest target wins.
//  - Arithmetic: PC increment modulo 2^ADDR_W (0xFFFF_FFFC+4 -> 0x0). redirect_pc[1:0] masked.
//  - Simultaneous consume + transfer with skid empty: new word goes straight to output, no bubble.
// STRUCTURE
//  - cpu_pkg: OPCODE_MSB/LSB (31/26), INSTR_W=32, NOP word 32'h0000_0000, fetch state enum
//    {IDLE, FETCH, FULL}.
//  - One sub-module: fetch_skid_buf (2-entry output+skid register pair with valid bits, flush input).
//  - Top: state FSM, PC/kill registers, imem handshake, opcode/pc_plus4 derivation.
// TESTING
//  1. rst=1 for 3 cycles, release; imem_ready=1 always, rdata=addr -> imem_req rises cycle 1 at 0x0;
//     instr_valid cycle 2 with instr=0x0, then instr_pc 0x4, 0x8 each consecutive cycle.
//  2. Streaming, stall=1 for 3 cycles at instr_pc=0x8 -> instr 0x8 held; skid takes 0xC; imem_req=0 (FULL);
//     stall=0 -> 0xC, then 0x10 with no lost or duplicated instruction.
//  3. redirect_valid=1, redirect_pc=0x103, imem_ready=0 -> kill set, addr held; after ready, discarded;
//     next req addr=0x100; first valid instr_pc=0x100.
//  4. Redirect same cycle as imem_ready and stall=1 -> output and skid flushed; req at target next cycle.
//  5. RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 of last = 0x4.
//  6. rst asserted while imem_req=1 and stall=1 -> next cycle all outputs at reset values; late ready ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package cpu_pkg;
   localparam int INSTR_W    = 32;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam logic [INSTR_W-1:0] NOP = '0;

   typedef enum logic [1:0] {IDLE, FETCH, FULL} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one skid entry; the skid absorbs the word in flight when the consumer stalls.
module fetch_skid_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         skid_valid
);
   logic [W-1:0] skid_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_data   <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!out_valid || pop) begin
         // Output slot frees up: skid drains first to keep program order.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= push;
            if (push) skid_data <= push_data;
         end else begin
            out_valid <= push;
            if (push) out_data <= push_data;
         end
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_data  <= push_data;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, handshakes with instruction memory, and feeds the datapath one word at a time.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [5:0]        opcode
);
   localparam int ENTRY_W = INSTR_W + 2 * ADDR_W;

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc, pc_inc, kill_pc, redirect_tgt;
   logic              kill, transfer, push, pop, skid_valid;
   logic [1:0]        occ_nxt;
   logic [ENTRY_W-1:0] out_data;

   assign imem_req     = (state == FETCH);
   assign imem_addr    = pc;
   assign pc_inc       = pc + ADDR_W'(4);
   assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
   assign transfer     = imem_req & imem_ready;
   // Words returning for a killed request or during a redirect never enter the pipe.
   assign push         = transfer & ~kill & ~redirect_valid;
   assign pop          = instr_valid & ~stall;
   assign occ_nxt      = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, push} - {1'b0, pop};

   fetch_skid_buf #(.W(ENTRY_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_data  ({imem_rdata, pc, pc_inc}),
      .pop        (pop),
      .out_valid  (instr_valid),
      .out_data   (out_data),
      .skid_valid (skid_valid)
   );

   assign {instr, instr_pc, pc_plus4} = out_data;
   assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         kill    <= 1'b0;
         kill_pc <= '0;
      end else if (redirect_valid) begin
         // A pending request must keep its address until accepted, so park the target.
         if (imem_req && !imem_ready) begin
            kill    <= 1'b1;
            kill_pc <= redirect_tgt;
         end else begin
            state <= FETCH;
            pc    <= redirect_tgt;
            kill  <= 1'b0;
         end
      end else if (kill) begin
         if (transfer) begin
            pc   <= kill_pc;
            kill <= 1'b0;
         end
      end else begin
         case (state)
            IDLE:    state <= FETCH;
            FETCH:   if (transfer) begin
                        pc <= pc_inc;
                        if (occ_nxt == 2'd2) state <= FULL;
                     end
            FULL:    if (pop) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions queued at issue, a negedge monitor checks each consume.
module tb_fetch_unit;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [5:0]  op;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, imem_ready, stall, redirect_valid;
   logic [31:0] redirect_pc, mask;
   logic        imem_req, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus4;
   logic [5:0]  opcode;

   logic        hi_req, hi_valid;
   logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pc, hi_pc4;
   logic [5:0]  hi_op;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ mask;
   assign hi_rdata   = hi_addr;

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc_plus4(pc_plus4), .opcode(opcode)
   );

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
      .clk(clk), .rst(rst), .imem_req(hi_req), .imem_addr(hi_addr),
      .imem_ready(1'b1), .imem_rdata(hi_rdata), .stall(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instr_valid(hi_valid), .instr(hi_instr), .instr_pc(hi_pc),
      .pc_plus4(hi_pc4), .opcode(hi_op)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.instr = pc ^ mask;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      e.op    = e.instr[31:26];
      q.push_back(e);
   endtask

   task automatic chk_reset_state();
      chk("rst_req",   {31'b0, imem_req}, 32'h0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc",    instr_pc, 32'h0);
      chk("rst_pc4",   pc_plus4, 32'h0);
      chk("rst_op",    {26'b0, opcode}, 32'h0);
   endtask

   // Scoreboard monitor: every consumed instruction must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && instr_valid && !stall) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got pc %h, expected no instruction", instr_pc);
         end else begin
            mon_e = q.pop_front();
            chk("sb_instr", instr, mon_e.instr);
            chk("sb_pc", instr_pc, mon_e.pc);
            chk("sb_pc4", pc_plus4, mon_e.pc4);
            chk("sb_op", {26'b0, opcode}, {26'b0, mon_e.op});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; imem_ready = 1'b1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; mask = 32'h0;
      repeat (3) tick();
      chk_reset_state();

      // Streaming from reset, then a 3-cycle stall at pc 0x8.
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      push_exp(32'hC); push_exp(32'h10); push_exp(32'h14);
      rst = 1'b0;
      tick();
      chk("t1_req", {31'b0, imem_req}, 32'h1);
      chk("t1_addr", imem_addr, 32'h0);
      chk("t1_valid0", {31'b0, instr_valid}, 32'h0);
      tick();
      chk("t1_first_valid", {31'b0, instr_valid}, 32'h1);
      chk("t5_pc0", hi_pc, 32'hFFFF_FFF8);
      tick();
      chk("t5_pc1", hi_pc, 32'hFFFF_FFFC);
      chk("t5_op1", {26'b0, hi_op}, 32'h3F);
      tick();
      chk("t5_pc2", hi_pc, 32'h0);
      chk("t5_pc4", hi_pc4, 32'h4);
      chk("t5_valid", {31'b0, hi_valid}, 32'h1);
      chk("t1_pc8", instr_pc, 32'h8);
      stall = 1'b1;
      tick();
      chk("t2_hold", instr_pc, 32'h8);
      chk("t2_full_req", {31'b0, imem_req}, 32'h0);
      tick(); tick();
      chk("t2_hold3", instr_pc, 32'h8);
      stall = 1'b0;
      tick();
      chk("t2_skid_out", instr_pc, 32'hC);
      chk("t2_req_back", {31'b0, imem_req}, 32'h1);
      chk("t2_addr", imem_addr, 32'h10);
      tick();
      chk("t2_next", instr_pc, 32'h10);
      tick();
      chk("t2_next2", instr_pc, 32'h14);
      imem_ready = 1'b0;
      tick();
      chk("t2_empty", {31'b0, instr_valid}, 32'h0);
      chk("t2_wait_addr", imem_addr, 32'h18);

      // Redirect while a request is outstanding and not yet accepted.
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      chk("t3_kill_valid", {31'b0, instr_valid}, 32'h0);
      chk("t3_kill_req", {31'b0, imem_req}, 32'h1);
      chk("t3_kill_addr", imem_addr, 32'h18);
      tick();
      chk("t3_kill_addr2", imem_addr, 32'h18);
      imem_ready = 1'b1;
      tick();
      chk("t3_new_addr", imem_addr, 32'h100);
      chk("t3_discard", {31'b0, instr_valid}, 32'h0);
      tick();
      chk("t3_first_pc", instr_pc, 32'h100);
      chk("t3_first_pc4", pc_plus4, 32'h104);
      chk("t3_first_valid", {31'b0, instr_valid}, 32'h1);

      // Redirect coinciding with a transfer while stalled, then with a full skid.
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk("t4_flush_valid", {31'b0, instr_valid}, 32'h0);
      chk("t4_req", {31'b0, imem_req}, 32'h1);
      chk("t4_addr", imem_addr, 32'h200);
      tick();
      chk("t4_out", instr_pc, 32'h200);
      tick();
      chk("t4_full_req", {31'b0, imem_req}, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF5;
      tick();
      redirect_valid = 1'b0;
      chk("t4_flush2_valid", {31'b0, instr_valid}, 32'h0);
      chk("t4_flush2_req", {31'b0, imem_req}, 32'h1);
      chk("t4_flush2_addr", imem_addr, 32'hFFFF_FFF4);

      // Wraparound stream with instr distinct from pc.
      mask = 32'h5A5A_0000;
      push_exp(32'hFFFF_FFF4); push_exp(32'hFFFF_FFF8); push_exp(32'hFFFF_FFFC);
      push_exp(32'h0); push_exp(32'h4);
      stall = 1'b0;
      tick(); tick(); tick();
      chk("t5_wrap_pc", instr_pc, 32'hFFFF_FFFC);
      chk("t5_wrap_pc4", pc_plus4, 32'h0);
      tick(); tick();
      chk("t5_wrap_last", instr_pc, 32'h4);
      imem_ready = 1'b0;
      tick();
      chk("t5_drained", {31'b0, instr_valid}, 32'h0);

      // Reset while a request is pending and the output is stalled.
      stall = 1'b1; imem_ready = 1'b1;
      tick();
      chk("t6_held_pc", instr_pc, 32'h8);
      chk("t6_held_instr", instr, 32'h5A5A_0008);
      rst = 1'b1; imem_ready = 1'b0;
      tick();
      chk_reset_state();
      rst = 1'b0; imem_ready = 1'b1; stall = 1'b0;
      tick();
      chk("t6_req", {31'b0, imem_req}, 32'h1);
      chk("t6_addr", imem_addr, 32'h0);
      chk("t6_late_ready", {31'b0, instr_valid}, 32'h0);
      imem_ready = 1'b0;
      tick();
      chk("t6_still_empty", {31'b0, instr_valid}, 32'h0);
      chk("t6_addr_hold", imem_addr, 32'h0);

      for (int i = 0; i < 20 && q.size() != 0; i++) tick();
      chk("sb_drained", 32'(q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
